// File: rtl/rom_loader_pkg.sv
// ----------------------------------------------------------------------------
// Package : rom_loader_pkg
// Shared load/fetch control encoding for the ROM image path.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rom_loader_pkg;

   // Control states shared with the sequential fetch side.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } ld_state_e;

endpackage : rom_loader_pkg

`default_nettype wire

// File: rtl/rom_loader.sv
// ----------------------------------------------------------------------------
// Module  : rom_loader
// Streams words from a valid/ready interface into an external synchronous
// memory at ascending addresses from 0, stopping on in_last or on the final
// address. Memory-side outputs are registered.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   count
);

   localparam logic [ADDR_WIDTH-1:0] C_ADDR_MAX = '1;

   ld_state_e               state_q,     state_d;
   logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
   logic [ADDR_WIDTH:0]     count_q,     count_d;
   logic                    mem_we_q,    mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q,  mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

   // Next-state, address counter and write-stage decode.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      count_d     = count_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         IDLE, DONE: begin
            // Input words are ignored here; only start has an effect.
            if (start) begin
               state_d = LOAD;
               addr_d  = '0;
               count_d = '0;
            end
         end
         LOAD: begin
            // in_ready is the LOAD decode, so in_valid alone means accept.
            if (in_valid) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = in_data;
               count_d     = count_q + 1'b1;
               if (in_last || (addr_q == C_ADDR_MAX)) begin
                  // Hold addr at the top rather than wrapping to 0.
                  state_d = DONE;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output register stage with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         count_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign in_ready  = (state_q == LOAD);
   assign busy      = (state_q == LOAD);
   assign done      = (state_q == DONE);
   assign count     = count_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule : rom_loader

`default_nettype wire

// File: tb/tb_rom_loader.sv
// ----------------------------------------------------------------------------
// Module  : tb_rom_loader
// Bench for rom_loader paired with a simple synchronous memory model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rom_loader;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          busy;
   logic          done;
   logic [AW:0]   count;

   int errors = 0;
   int checks = 0;

   // Reference model: abstract loader status plus expected memory image.
   bit            m_loading;
   bit            m_done;
   int            m_next;
   int            m_count;
   bit            m_we;
   int            m_waddr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] exp_mem [DEPTH] = '{default: '0};

   // Synchronous memory model fed by the loader.
   logic [DW-1:0] mem [DEPTH] = '{default: '0};

   rom_loader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .count     (count)
   );

   always #5 clk = ~clk;

   // Memory write port.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the model, then check all outputs.
   task automatic step(input bit r, input bit s, input bit v,
                       input logic [DW-1:0] d, input bit l);
      rst_n    = ~r;
      start    = s;
      in_valid = v;
      in_data  = d;
      in_last  = l;
      @(posedge clk);
      if (r) begin
         m_loading = 0; m_done = 0; m_next = 0; m_count = 0;
         m_we = 0; m_waddr = 0; m_wdata = '0;
      end else if (m_loading && v) begin
         m_we    = 1;
         m_waddr = m_next;
         m_wdata = d;
         exp_mem[m_next] = d;
         m_next++;
         m_count++;
         if (l || m_next == DEPTH) begin
            m_loading = 0;
            m_done    = 1;
         end
      end else begin
         m_we = 0;
         if (s && !m_loading) begin
            m_loading = 1; m_done = 0; m_next = 0; m_count = 0;
         end
      end
      #1;
      chk("in_ready",  64'(in_ready),  64'(m_loading));
      chk("busy",      64'(busy),      64'(m_loading));
      chk("done",      64'(done),      64'(m_done));
      chk("count",     64'(count),     64'(m_count));
      chk("mem_we",    64'(mem_we),    64'(m_we));
      chk("mem_addr",  64'(mem_addr),  64'(m_waddr));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, DW'($urandom), 0);
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < DEPTH; i++) chk(tag, 64'(mem[i]), 64'(exp_mem[i]));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;

      // Reset for two cycles.
      step(1, 0, 0, '0, 0);
      step(1, 0, 1, DW'($urandom), 0);
      idle(1);

      // Full load of 16 back-to-back words.
      step(0, 1, 0, '0, 0);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1, DW'(32'hA0 + i), 0);
      idle(2);
      chk("full_count", 64'(count), 64'(DEPTH));
      check_mem("full_mem");

      // Early stop on in_last at the fifth word.
      step(0, 1, 0, '0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, DW'($urandom), (i == 4));
      step(0, 0, 1, DW'($urandom), 0);
      idle(2);
      check_mem("early_mem");

      // Gapped valid pattern 1,0,1,1,0,1.
      step(0, 1, 0, '0, 0);
      begin
         bit pat [6] = '{1, 0, 1, 1, 0, 1};
         for (int i = 0; i < 6; i++) step(0, 0, pat[i], DW'($urandom), 0);
      end
      step(0, 0, 1, DW'($urandom), 1);
      idle(2);
      check_mem("gap_mem");

      // Reset mid-load after three accepts, then reload.
      step(0, 1, 0, '0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, DW'($urandom), 0);
      step(1, 0, 1, DW'($urandom), 0);
      step(0, 0, 1, DW'($urandom), 0);
      step(0, 1, 1, DW'($urandom), 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, DW'($urandom), (i == 3));
      idle(2);
      check_mem("rst_mem");

      // Ignored inputs: valid in DONE/IDLE, start during LOAD.
      for (int i = 0; i < 3; i++) step(0, 0, 1, DW'($urandom), 0);
      step(1, 0, 0, '0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, DW'($urandom), 1);
      step(0, 1, 1, DW'($urandom), 0);
      step(0, 0, 1, DW'($urandom), 0);
      step(0, 1, 1, DW'($urandom), 0);
      step(0, 1, 0, '0, 0);
      step(0, 0, 1, DW'($urandom), 1);
      idle(2);
      check_mem("ign_mem");

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 3) != 0),
              DW'($urandom),
              ($urandom_range(0, 19) == 0));
      end
      idle(2);
      check_mem("rand_mem");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_rom_loader

`default_nettype wire
